// File: rtl/mux_arb_pkg.sv
// Shared constants, FSM state type and one-hot helper for the 4-way round-robin mux arbiter.
package mux_arb_pkg;
  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first set request searching ptr, ptr+1, ... mod 4.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] pick,
  output logic       any
);
  logic [1:0] idx;

  // Scan from farthest to nearest so the closest request to ptr wins last.
  always_comb begin
    pick = '0;
    idx  = '0;
    any  = |req;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) pick = idx;
    end
  end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner arbiter for a shared 4:1 mux; registered grant/select/busy/preempt.
// Optional hold-timeout preemption is built when MUX_ARB_TIMEOUT_EN is defined.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic [1:0] select,
  output logic       busy,
  output logic       preempt
);
  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("MAX_HOLD must be >= 2");
  end

  arb_state_t state_q;
  logic [1:0] ptr_q;
  logic [3:0] grant_q;
  logic [1:0] select_q;
  logic       busy_q;
  logic       preempt_q;

  logic [1:0] pick;
  logic       any;
  logic       timeout;
  logic       rel;

  rr_pick4 u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (any)
  );

  // select_q names the owner while BUSY; grant_q is its one-hot form.
  assign rel = done || !req[select_q] || timeout;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int                CNT_W   = $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] cnt_q;

  assign timeout = (state_q == BUSY) && (cnt_q == CNT_MAX) && |(req & ~grant_q);

  // Counts BUSY cycles from 0 at grant; saturates while nobody else waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         cnt_q <= '0;
    else if (state_q != BUSY || rel)    cnt_q <= '0;
    else if (cnt_q != CNT_MAX)          cnt_q <= cnt_q + CNT_W'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      select_q  <= '0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        IDLE: if (any) begin
          state_q  <= BUSY;
          grant_q  <= onehot(pick);
          select_q <= pick;
          busy_q   <= 1'b1;
        end
        BUSY: if (rel) begin
          // select_q is kept so the mux output stays stable through the bubble.
          state_q   <= IDLE;
          grant_q   <= '0;
          busy_q    <= 1'b0;
          ptr_q     <= select_q + 2'd1;
          preempt_q <= timeout;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant   = grant_q;
  assign select  = select_q;
  assign busy    = busy_q;
  assign preempt = preempt_q;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter; expected grants queued at stimulus, popped at grant.
module tb_mux4_rr_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       done;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] select;
  logic       busy;
  logic       preempt;

  int n_pass  = 0;
  int n_total = 0;
  logic [5:0] exp_q[$];
  logic [5:0] e;

  mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .select  (select),
    .busy    (busy),
    .preempt (preempt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; done = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; done = 1'b0;
    tick();
    n_total++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", grant); else n_pass++;
    n_total++; if (select !== 2'd0) $display("FAIL reset_select: got %0d want 0", select); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (preempt !== 1'b0) $display("FAIL reset_preempt: got %b want 0", preempt); else n_pass++;
    req = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    req = 4'b0101;
    exp_q.push_back({4'b0001, 2'd0});
    tick();
    e = exp_q.pop_front();
    n_total++; if (grant !== e[5:2]) $display("FAIL basic_grant0: got %b want %b", grant, e[5:2]); else n_pass++;
    n_total++; if (select !== e[1:0]) $display("FAIL basic_select0: got %0d want %0d", select, e[1:0]); else n_pass++;
    n_total++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else n_pass++;
    done = 1'b1;
    exp_q.push_back({4'b0100, 2'd2});
    tick();
    n_total++; if (grant !== 4'b0000) $display("FAIL basic_release: got %b want 0000", grant); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL basic_idle_busy: got %b want 0", busy); else n_pass++;
    done = 1'b0;
    tick();
    e = exp_q.pop_front();
    n_total++; if (grant !== e[5:2]) $display("FAIL basic_grant1: got %b want %b", grant, e[5:2]); else n_pass++;
    n_total++; if (select !== e[1:0]) $display("FAIL basic_select1: got %0d want %0d", select, e[1:0]); else n_pass++;
    req = '0;
    tick();
  endtask

  task automatic test_rr_order();
    logic [3:0] oh;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      oh = 4'b0001 << (i % 4);
      exp_q.push_back({oh, 2'(i % 4)});
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      e = exp_q.pop_front();
      n_total++; if (grant !== e[5:2]) $display("FAIL rr_grant%0d: got %b want %b", i, grant, e[5:2]); else n_pass++;
      n_total++; if (select !== e[1:0]) $display("FAIL rr_select%0d: got %0d want %0d", i, select, e[1:0]); else n_pass++;
      done = 1'b1;
      tick();
      done = 1'b0;
      n_total++; if (grant !== 4'b0000) $display("FAIL rr_bubble%0d: got %b want 0000", i, grant); else n_pass++;
    end
    req = '0;
    tick();
  endtask

  task automatic test_drop();
    do_reset();
    req = 4'b0100;
    exp_q.push_back({4'b0100, 2'd2});
    tick();
    e = exp_q.pop_front();
    n_total++; if (grant !== e[5:2]) $display("FAIL drop_grant: got %b want %b", grant, e[5:2]); else n_pass++;
    req = 4'b0000;
    tick();
    n_total++; if (grant !== 4'b0000) $display("FAIL drop_release: got %b want 0000", grant); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL drop_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (select !== 2'd2) $display("FAIL drop_select: got %0d want 2", select); else n_pass++;
    tick();
    n_total++; if (select !== 2'd2) $display("FAIL drop_select_idle: got %0d want 2", select); else n_pass++;
  endtask

  task automatic test_hold();
    do_reset();
    req = 4'b0011;
    exp_q.push_back({4'b0001, 2'd0});
    tick();
    e = exp_q.pop_front();
    n_total++; if (grant !== e[5:2]) $display("FAIL hold_grant: got %b want %b", grant, e[5:2]); else n_pass++;
`ifdef MUX_ARB_TIMEOUT_EN
    for (int c = 1; c < 4; c++) begin
      tick();
      n_total++; if (grant !== 4'b0001 || preempt !== 1'b0)
        $display("FAIL hold_busy%0d: got grant %b preempt %b want 0001/0", c, grant, preempt); else n_pass++;
    end
    exp_q.push_back({4'b0010, 2'd1});
    tick();
    n_total++; if (grant !== 4'b0000) $display("FAIL timeout_release: got %b want 0000", grant); else n_pass++;
    n_total++; if (preempt !== 1'b1) $display("FAIL timeout_preempt: got %b want 1", preempt); else n_pass++;
    tick();
    e = exp_q.pop_front();
    n_total++; if (grant !== e[5:2]) $display("FAIL timeout_next: got %b want %b", grant, e[5:2]); else n_pass++;
    n_total++; if (preempt !== 1'b0) $display("FAIL timeout_pulse: got %b want 0", preempt); else n_pass++;
`else
    for (int c = 0; c < 22; c++) begin
      tick();
      n_total++; if (grant !== 4'b0001 || preempt !== 1'b0)
        $display("FAIL hold_busy%0d: got grant %b preempt %b want 0001/0", c, grant, preempt); else n_pass++;
    end
`endif
    req = '0; done = 1'b1;
    tick();
    done = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b1000;
    tick();
    n_total++; if (grant !== 4'b1000 || select !== 2'd3)
      $display("FAIL areset_owner: got %b/%0d want 1000/3", grant, select); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (grant !== 4'b0000) $display("FAIL areset_grant: got %b want 0000", grant); else n_pass++;
    n_total++; if (select !== 2'd0) $display("FAIL areset_select: got %0d want 0", select); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL areset_busy: got %b want 0", busy); else n_pass++;
    req = 4'b1111;
    exp_q.push_back({4'b0001, 2'd0});
    #2 rst_n = 1'b1;
    tick();
    e = exp_q.pop_front();
    n_total++; if (grant !== e[5:2]) $display("FAIL areset_first: got %b want %b", grant, e[5:2]); else n_pass++;
    n_total++; if (select !== e[1:0]) $display("FAIL areset_first_sel: got %0d want %0d", select, e[1:0]); else n_pass++;
    req = '0;
    tick();
  endtask

  task automatic test_idle_done();
    do_reset();
    req = 4'b0000; done = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_total++; if (grant !== 4'b0000 || busy !== 1'b0)
        $display("FAIL idle_done%0d: got grant %b busy %b want 0000/0", c, grant, busy); else n_pass++;
    end
    done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; done = 1'b0;
    test_reset();
    test_basic();
    test_rr_order();
    test_drop();
    test_hold();
    test_async_reset();
    test_idle_done();
    n_total++; if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
